// File: rtl/speed_ctrl_filt_pkg.sv
// Shared ADPCM package for the speed-control filter: widths, shift constants,
// AX threshold, sequencer states and the DMS/DML update helpers.
package speed_ctrl_filt_pkg;

  localparam int unsigned FI_W      = 3;
  localparam int unsigned DMS_W     = 12;
  localparam int unsigned DML_W     = 14;
  localparam int unsigned Y_W       = 13;
  localparam int unsigned DMS_SHIFT = 5;
  localparam int unsigned DML_SHIFT = 7;

  localparam logic [Y_W-1:0] Y_THR = 13'd1536;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } state_e;

  // Arithmetic shift of the signed difference floors toward minus infinity;
  // the sum keeps only the register width, so overflow wraps.
  function automatic logic [DMS_W-1:0] dms_next(input logic [DMS_W-1:0] dms,
                                                input logic [FI_W-1:0]  fi);
    logic signed [12:0] dif;
    logic signed [12:0] step;
    dif  = $signed({1'b0, fi, 9'd0}) - $signed({1'b0, dms});
    step = dif >>> DMS_SHIFT;
    return dms + step[DMS_W-1:0];
  endfunction

  function automatic logic [DML_W-1:0] dml_next(input logic [DML_W-1:0] dml,
                                                input logic [FI_W-1:0]  fi);
    logic signed [14:0] dif;
    logic signed [14:0] step;
    dif  = $signed({1'b0, fi, 11'd0}) - $signed({1'b0, dml});
    step = dif >>> DML_SHIFT;
    return dml + step[DML_W-1:0];
  endfunction

endpackage

// File: rtl/speed_ctrl_filt_ax.sv
// speed_ctrl_ax: second pipeline stage computing the registered AX speed-control
// indication from one DMS/DML update and the Y/TDP captured with it.
module speed_ctrl_ax
  import speed_ctrl_filt_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [DMS_W-1:0] dms_i,
  input  logic [DML_W-1:0] dml_i,
  input  logic [Y_W-1:0]   y_i,
  input  logic             tdp_i,
  output logic             ax_o,
  output logic             ax_valid_o
);

  logic [14:0] dif_s;
  logic [14:0] difm_s;
  logic        ax_d;
  logic        ax_q;
  logic        ax_valid_q;

  // AX drops to 0 only for a large scale factor, a settled short/long average and no tone
  always_comb begin
    dif_s  = {1'b0, dms_i, 2'b00} - {1'b0, dml_i};
    difm_s = dif_s[14] ? (15'd0 - dif_s) : dif_s;
    if ((y_i >= Y_THR) && (difm_s < {4'b0000, dml_i[DML_W-1:3]}) && !tdp_i) begin
      ax_d = 1'b0;
    end else begin
      ax_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ax_q       <= 1'b0;
      ax_valid_q <= 1'b0;
    end else begin
      ax_valid_q <= valid_i;
      if (valid_i) begin
        ax_q <= ax_d;
      end else begin
        ax_q <= ax_q;
      end
    end
  end

  assign ax_o       = ax_q;
  assign ax_valid_o = ax_valid_q;

endmodule

// File: rtl/speed_ctrl_filt.sv
// speed_ctrl_filt: short/long-term averages of F(I) (DMS/DML) with a two-state
// sequencer. Optional AX stage enabled by macro SPEED_CTRL_AX_EN.
module speed_ctrl_filt
  import speed_ctrl_filt_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [FI_W-1:0]  FI,
  input  logic             FI_VALID,
`ifdef SPEED_CTRL_AX_EN
  input  logic [Y_W-1:0]   Y,
  input  logic             TDP,
  output logic             AX,
  output logic             AX_VALID,
`endif
  output logic [DMS_W-1:0] DMS,
  output logic [DML_W-1:0] DML,
  output logic             DM_VALID
);

  state_e           state_q, state_d;
  logic [DMS_W-1:0] dms_q, dms_d;
  logic [DML_W-1:0] dml_q, dml_d;

  // Sequencer next state and filter updates on accepted samples
  always_comb begin
    state_d = state_q;
    dms_d   = dms_q;
    dml_d   = dml_q;
    case (state_q)
      ST_IDLE: begin
        if (FI_VALID) state_d = ST_UPDATE;
        else          state_d = ST_IDLE;
      end
      ST_UPDATE: begin
        if (FI_VALID) state_d = ST_UPDATE;
        else          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (FI_VALID) begin
      dms_d = dms_next(dms_q, FI);
      dml_d = dml_next(dml_q, FI);
    end else begin
      dms_d = dms_q;
      dml_d = dml_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      dms_q   <= 12'd0;
      dml_q   <= 14'd0;
    end else begin
      state_q <= state_d;
      dms_q   <= dms_d;
      dml_q   <= dml_d;
    end
  end

  assign DMS      = dms_q;
  assign DML      = dml_q;
  assign DM_VALID = (state_q == ST_UPDATE);

`ifdef SPEED_CTRL_AX_EN
  logic [Y_W-1:0] y_q;
  logic           tdp_q;

  // Y/TDP travel alongside the DMS/DML update made at the same edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      y_q   <= 13'd0;
      tdp_q <= 1'b0;
    end else if (FI_VALID) begin
      y_q   <= Y;
      tdp_q <= TDP;
    end else begin
      y_q   <= y_q;
      tdp_q <= tdp_q;
    end
  end

  speed_ctrl_ax u_ax (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .valid_i    (DM_VALID),
    .dms_i      (dms_q),
    .dml_i      (dml_q),
    .y_i        (y_q),
    .tdp_i      (tdp_q),
    .ax_o       (AX),
    .ax_valid_o (AX_VALID)
  );
`endif

endmodule

// File: tb/tb_speed_ctrl_filt.sv
// Self-checking bench for speed_ctrl_filt against an integer-arithmetic model
// (AX checks compiled when SPEED_CTRL_AX_EN is defined).
module tb_speed_ctrl_filt;

  logic        CLK;
  logic        RESET;
  logic [2:0]  FI;
  logic        FI_VALID;
  logic [11:0] DMS;
  logic [13:0] DML;
  logic        DM_VALID;
`ifdef SPEED_CTRL_AX_EN
  logic [12:0] Y;
  logic        TDP;
  logic        AX;
  logic        AX_VALID;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int dms_m, dml_m, valid_m;
  int y_m, tdp_m, ax_m, axv_m;

  speed_ctrl_filt dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .FI       (FI),
    .FI_VALID (FI_VALID),
`ifdef SPEED_CTRL_AX_EN
    .Y        (Y),
    .TDP      (TDP),
    .AX       (AX),
    .AX_VALID (AX_VALID),
`endif
    .DMS      (DMS),
    .DML      (DML),
    .DM_VALID (DM_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int wrap(input int a, input int m);
    return ((a % m) + m) % m;
  endfunction

  function automatic int ax_ref(input int dms, input int dml, input int y, input int tdp);
    int d;
    d = 4 * dms - dml;
    if (d < 0) d = -d;
    return (y >= 1536 && d < dml / 8 && tdp == 0) ? 0 : 1;
  endfunction

  task automatic model_reset();
    dms_m = 0; dml_m = 0; valid_m = 0;
    y_m = 0; tdp_m = 0; ax_m = 0; axv_m = 0;
  endtask

  // one clock edge of the model: output stage uses pre-edge averages
  task automatic model_edge(input int v, input int fi, input int y, input int tdp);
    axv_m = valid_m;
    if (valid_m != 0) ax_m = ax_ref(dms_m, dml_m, y_m, tdp_m);
    if (v != 0) begin
      y_m   = y;
      tdp_m = tdp;
      dms_m = wrap(dms_m + floor_div(fi * 512 - dms_m, 32), 4096);
      dml_m = wrap(dml_m + floor_div(fi * 2048 - dml_m, 128), 16384);
    end
    valid_m = v;
  endtask

  task automatic cycle(input int v, input int fi, input int y, input int tdp);
    FI_VALID = v[0];
    FI       = fi[2:0];
`ifdef SPEED_CTRL_AX_EN
    Y   = y[12:0];
    TDP = tdp[0];
`endif
    @(posedge CLK);
    #1;
    model_edge(v, fi, y, tdp);
  endtask

  task automatic apply_reset();
    RESET    = 1'b1;
    FI_VALID = 1'b0;
    FI       = 3'd0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    RESET    = 1'b1;
    FI_VALID = 1'b1;
    FI       = 3'd7;
    repeat (2) @(posedge CLK);
    #1;
    n_tests++; if (DMS !== 12'd0) begin n_fail++; $display("FAIL reset_dms got %0d want 0", DMS); end
    n_tests++; if (DML !== 14'd0) begin n_fail++; $display("FAIL reset_dml got %0d want 0", DML); end
    n_tests++; if (DM_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", DM_VALID); end
`ifdef SPEED_CTRL_AX_EN
    n_tests++; if (AX !== 1'b0 || AX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_ax got %b/%b want 0/0", AX, AX_VALID); end
`endif
    FI_VALID = 1'b0;
    RESET    = 1'b0;
    model_reset();
  endtask

  task automatic test_first_samples();
    apply_reset();
    cycle(1, 7, 1536, 0);
    n_tests++; if (DMS !== 12'd112) begin n_fail++; $display("FAIL first_dms got %0d want 112", DMS); end
    n_tests++; if (DML !== 14'd112) begin n_fail++; $display("FAIL first_dml got %0d want 112", DML); end
    n_tests++; if (DM_VALID !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", DM_VALID); end
`ifdef SPEED_CTRL_AX_EN
    n_tests++; if (AX_VALID !== 1'b0) begin n_fail++; $display("FAIL first_axv_early got %b want 0", AX_VALID); end
`endif
    cycle(1, 0, 1536, 0);
    n_tests++; if (DMS !== 12'd108) begin n_fail++; $display("FAIL floor_dms got %0d want 108", DMS); end
    n_tests++; if (DML !== 14'd111) begin n_fail++; $display("FAIL floor_dml got %0d want 111", DML); end
`ifdef SPEED_CTRL_AX_EN
    n_tests++; if (AX !== 1'b1 || AX_VALID !== 1'b1) begin n_fail++; $display("FAIL ax_112 got %b/%b want 1/1", AX, AX_VALID); end
`endif
    for (int i = 0; i < 2; i++) begin
      cycle(0, 5, 0, 0);
      n_tests++; if (DMS !== 12'd108 || DML !== 14'd111) begin n_fail++; $display("FAIL hold got %0d/%0d want 108/111", DMS, DML); end
      n_tests++; if (DM_VALID !== 1'b0) begin n_fail++; $display("FAIL hold_valid got %b want 0", DM_VALID); end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] dms_mid;
    apply_reset();
    dms_mid = 12'd0;
    for (int i = 0; i < 400; i++) begin
      cycle(1, 7, 0, 0);
      n_tests++; if (DM_VALID !== 1'b1 || int'(DMS) != dms_m || int'(DML) != dml_m) begin
        n_fail++; $display("FAIL b2b[%0d] got %b/%0d/%0d want 1/%0d/%0d", i, DM_VALID, DMS, DML, dms_m, dml_m);
      end
      if (i == 299) dms_mid = DMS;
    end
    n_tests++; if (DMS < 12'd3553 || DMS > 12'd3584) begin n_fail++; $display("FAIL b2b_range got %0d want 3553..3584", DMS); end
    n_tests++; if (DMS !== dms_mid) begin n_fail++; $display("FAIL b2b_settled got %0d want %0d", DMS, dms_mid); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    cycle(1, 5, 2000, 0);
    FI_VALID = 1'b1;
    FI       = 3'd7;
    RESET    = 1'b1;
    #1;
    n_tests++; if (DMS !== 12'd0 || DML !== 14'd0) begin n_fail++; $display("FAIL midrst_clear got %0d/%0d want 0/0", DMS, DML); end
    n_tests++; if (DM_VALID !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", DM_VALID); end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 7, 0, 0);
      n_tests++; if (DM_VALID !== 1'b0 || DMS !== 12'd0) begin n_fail++; $display("FAIL midrst_nopulse got %b/%0d want 0/0", DM_VALID, DMS); end
`ifdef SPEED_CTRL_AX_EN
      n_tests++; if (AX_VALID !== 1'b0) begin n_fail++; $display("FAIL midrst_axv got %b want 0", AX_VALID); end
`endif
    end
    // sample in the very first cycle after release
    apply_reset();
    cycle(1, 3, 0, 0);
    n_tests++; if (DMS !== 12'd48 || DML !== 14'd48 || DM_VALID !== 1'b1) begin
      n_fail++; $display("FAIL release got %0d/%0d/%b want 48/48/1", DMS, DML, DM_VALID);
    end
  endtask

  task automatic test_random();
    int v, fi, y, tdp;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      fi  = (i < 300) ? int'($urandom_range(0, 7)) : int'($urandom_range(5, 7));
      y   = (i < 300) ? int'($urandom_range(0, 8191)) : int'($urandom_range(1400, 2000));
      tdp = ($urandom_range(0, 7) == 0) ? 1 : 0;
      cycle(v, fi, y, tdp);
      n_tests++; if (int'(DMS) != dms_m || int'(DML) != dml_m || int'(DM_VALID) != valid_m) begin
        n_fail++; $display("FAIL rand[%0d] got %0d/%0d/%b want %0d/%0d/%0d", i, DMS, DML, DM_VALID, dms_m, dml_m, valid_m);
      end
`ifdef SPEED_CTRL_AX_EN
      n_tests++; if (int'(AX) != ax_m || int'(AX_VALID) != axv_m) begin
        n_fail++; $display("FAIL rand_ax[%0d] got %b/%b want %0d/%0d", i, AX, AX_VALID, ax_m, axv_m);
      end
`endif
    end
  endtask

`ifdef SPEED_CTRL_AX_EN
  task automatic test_ax_zero_input();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 4000, 0);
      if (i >= 1) begin
        n_tests++; if (AX !== 1'b1 || AX_VALID !== 1'b1) begin n_fail++; $display("FAIL ax_zero got %b/%b want 1/1", AX, AX_VALID); end
      end
    end
  endtask
`endif

  initial begin
    RESET    = 1'b0;
    FI       = 3'd0;
    FI_VALID = 1'b0;
`ifdef SPEED_CTRL_AX_EN
    Y   = 13'd0;
    TDP = 1'b0;
`endif
    model_reset();
    test_reset();
    test_first_samples();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef SPEED_CTRL_AX_EN
    test_ax_zero_input();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
